// File: rtl/exe_muldiv_ctrl_pkg.sv
// rtl/exe_muldiv_ctrl_pkg.sv - shared types and constants for the mul/div sequencer
// Purpose: op and state encodings, default widths, divide-by-zero quotient.
package exe_muldiv_ctrl_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Quotient reported when the divisor is zero.
  localparam logic [WIDTH_DEF-1:0] DIVZ_QUOT = '1;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/exe_muldiv_ctrl_if.sv
// rtl/exe_muldiv_ctrl_if.sv - EXE-stage <-> mul/div sequencer signal bundle
// Purpose: groups the request (start/op/operands/flush) and response
// (stall/done/hi/lo/div_zero) signals.
//   master: EXE stage / hazard logic side
//   slave : exe_muldiv_ctrl side
interface exe_muldiv_ctrl_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, op_a, op_b, flush,
    input  stall, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, op_a, op_b, flush,
    output stall, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - conditional two's-complement of a magnitude pair
// Purpose: converts magnitude results to signed hi/lo, and magnitudes of
// signed operands at entry.
//   op_i               : operation; multiply negates {hi,lo} as one 2*WIDTH value
//   mag_hi_i, mag_lo_i : magnitude inputs
//   neg_lo_i           : negate lo (divide) or whole product (multiply)
//   neg_hi_i           : negate hi (divide only)
//   res_hi_o, res_lo_o : results
module muldiv_sign_fix
  import exe_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] mag_hi_i,
  input  logic [WIDTH-1:0] mag_lo_i,
  input  logic             neg_lo_i,
  input  logic             neg_hi_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  logic [2*WIDTH-1:0] wide_neg;

  assign wide_neg = -{mag_hi_i, mag_lo_i};

  always_comb begin
    res_hi_o = mag_hi_i;
    res_lo_o = mag_lo_i;
    if (op_is_div(op_i)) begin
      if (neg_lo_i) res_lo_o = -mag_lo_i;
      if (neg_hi_i) res_hi_o = -mag_hi_i;
    end else if (neg_lo_i) begin
      {res_hi_o, res_lo_o} = wide_neg;
    end
  end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// rtl/exe_muldiv_ctrl.sv - bit-serial multiply/divide sequencer beside the EXE ALU
// Purpose: runs MULTU/MULT/DIVU/DIV one bit per cycle, stalls the pipeline
// while busy, and commits HI/LO on completion.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of exe_muldiv_ctrl_if
module exe_muldiv_ctrl
  import exe_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  exe_muldiv_ctrl_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  op_e                op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_dvd_q, neg_dvd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;
  logic               stall_c, done_c;

  op_e                op_in;
  logic               in_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign op_in     = op_e'(bus.op);
  assign in_signed = op_is_signed(op_in);

  // Operand magnitudes: divide mode negates each half independently.
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs (
    .op_i     (OP_DIV),
    .mag_hi_i (bus.op_b),
    .mag_lo_i (bus.op_a),
    .neg_lo_i (in_signed & bus.op_a[WIDTH-1]),
    .neg_hi_i (in_signed & bus.op_b[WIDTH-1]),
    .res_hi_o (b_abs),
    .res_lo_o (a_abs)
  );

  // Multiply: acc = {partial product, remaining multiplier bits}; add the
  // multiplicand when the current multiplier bit is set, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient bits}. Trial subtract is
  // WIDTH+1 bits because the shifted remainder may exceed WIDTH bits.
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
  assign div_next  = div_trial[WIDTH]
                   ? {acc_q[2*WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign acc_step = op_is_div(op_q) ? div_next : mul_next;

  // Sign fix is applied to the value produced by the final iteration.
  muldiv_sign_fix #(.WIDTH(WIDTH)) u_res (
    .op_i     (op_q),
    .mag_hi_i (acc_step[2*WIDTH-1:WIDTH]),
    .mag_lo_i (acc_step[WIDTH-1:0]),
    .neg_lo_i (neg_res_q),
    .neg_hi_i (neg_dvd_q),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    op_d       = op_q;
    neg_res_d  = neg_res_q;
    neg_dvd_d  = neg_dvd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    stall_c    = 1'b0;
    done_c     = 1'b0;

    case (state_q)
      ST_CALC: begin
        stall_c = 1'b1;
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            hi_d    = res_hi;
            lo_d    = res_lo;
          end
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: ;
    endcase

    // New request accepted from IDLE, or back-to-back from DONE.
    if ((state_q == ST_IDLE || state_q == ST_DONE) && bus.start && !bus.flush) begin
      stall_c    = 1'b1;
      op_d       = op_in;
      neg_res_d  = in_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
      neg_dvd_d  = in_signed & bus.op_a[WIDTH-1];
      b_d        = b_abs;
      acc_d      = {{WIDTH{1'b0}}, a_abs};
      cnt_d      = CNT_W'(WIDTH);
      div_zero_d = 1'b0;
      if (op_is_div(op_in) && bus.op_b == '0) begin
        state_d    = ST_DONE;
        hi_d       = bus.op_a;
        lo_d       = DIVZ_QUOT;
        div_zero_d = 1'b1;
      end else begin
        state_d = ST_CALC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      op_q       <= OP_MULTU;
      neg_res_q  <= 1'b0;
      neg_dvd_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      op_q       <= op_d;
      neg_res_q  <= neg_res_d;
      neg_dvd_q  <= neg_dvd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  // stall is combinational on start; hold it low while reset is asserted.
  assign bus.stall    = stall_c & rst;
  assign bus.done     = done_c;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// tb/tb_exe_muldiv_ctrl.sv - randomized self-checking bench for exe_muldiv_ctrl
module tb_exe_muldiv_ctrl;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exe_muldiv_ctrl_if #(.WIDTH(W)) bus ();

  exe_muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural reference: plain arithmetic on the operation rules.
  task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
    logic [63:0]        p;
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb;
    sa = a; sb = b; edz = 1'b0;
    case (op)
      2'd0: begin p = {32'd0, a} * {32'd0, b}; {ehi, elo} = p; end
      2'd1: begin sp = 64'(sa) * 64'(sb); {ehi, elo} = sp; end
      default: begin
        if (b == 32'd0) begin
          elo = 32'hFFFF_FFFF; ehi = a; edz = 1'b1;
        end else if (op == 2'd2) begin
          elo = a / b; ehi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          elo = 32'h8000_0000; ehi = 32'd0;
        end else begin
          elo = sa / sb; ehi = sa % sb;
        end
      end
    endcase
  endtask

  // Issues one op in the current cycle (IDLE or DONE) and follows it to done.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo;
    logic        edz;
    int          k, exp_lat;
    bit          seen;
    ref_model(op, a, b, ehi, elo, edz);
    exp_lat = edz ? 1 : W + 1;
    bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b; bus.flush = 1'b0;
    #1;
    n_checks++;
    if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL accept_stall: got %b expected 1", bus.stall); end
    k = 0; seen = 0;
    while (!seen && k < 3 * W) begin
      @(negedge clk);
      bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom;
      k++;
      #1;
      if (bus.done === 1'b1) seen = 1;
      else begin
        n_checks++;
        if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL busy_stall: cycle %0d got %b expected 1", k, bus.stall); end
      end
      if (k == 1 && !edz) begin
        n_checks++;
        if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL div_zero_clear: got %b expected 0", bus.div_zero); end
      end
    end
    n_checks++;
    if (!seen || k != exp_lat) begin n_fail++; $display("FAIL latency: op %0d got %0d cycles (done seen %0d) expected %0d", op, k, seen, exp_lat); end
    if (seen) begin
      n_checks++;
      if (bus.hi !== ehi) begin n_fail++; $display("FAIL hi: op %0d a %h b %h got %h expected %h", op, a, b, bus.hi, ehi); end
      n_checks++;
      if (bus.lo !== elo) begin n_fail++; $display("FAIL lo: op %0d a %h b %h got %h expected %h", op, a, b, bus.lo, elo); end
      n_checks++;
      if (bus.div_zero !== edz) begin n_fail++; $display("FAIL div_zero: got %b expected %b", bus.div_zero, edz); end
      n_checks++;
      if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL done_stall: got %b expected 0", bus.stall); end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b1; bus.op = 2'd0; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b expected 0", bus.div_zero); end
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    repeat (9) @(negedge clk);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk); run_op(2'd1, -32'sd7, 32'd6);
    @(negedge clk); run_op(2'd3, -32'sd7, 32'd2);
    @(negedge clk); run_op(2'd2, 32'd100, 32'd7);
    @(negedge clk); run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk); run_op(2'd1, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_divzero();
    @(negedge clk); run_op(2'd2, 32'd5, 32'd0);
    @(negedge clk); run_op(2'd0, 32'd3, 32'd4);
    @(negedge clk); run_op(2'd3, -32'sd9, 32'd0);
  endtask

  task automatic test_flush();
    bit any_done;
    @(negedge clk); run_op(2'd0, 32'd3, 32'd4);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.op_a = $urandom; bus.op_b = $urandom; bus.flush = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 10) bus.flush = 1'b1;
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", bus.stall); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL flush_hi: got %h expected 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'd12) begin n_fail++; $display("FAIL flush_lo: got %h expected c", bus.lo); end
    any_done = 0;
    repeat (W + 4) begin
      @(negedge clk); #1;
      if (bus.done === 1'b1 || bus.stall === 1'b1) any_done = 1;
    end
    n_checks++; if (any_done) begin n_fail++; $display("FAIL flush_quiet: got activity 1 expected 0"); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_op(2'd0, 32'd1234, 32'd5678);
    run_op(2'd3, 32'd1000, -32'sd3);
    run_op(2'd2, 32'd77, 32'd0);
    run_op(2'd1, $urandom, $urandom);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_op(2'($urandom_range(0, 3)), pick(), pick());
    end
  endtask

  task automatic test_reset_mid();
    bit any_done;
    @(negedge clk); run_op(2'd0, 32'd7, 32'd9);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'd3;
    repeat (5) begin @(negedge clk); bus.start = 1'b0; end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL midrst_hi: got %h expected 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL midrst_lo: got %h expected 0", bus.lo); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %b expected 0", bus.stall); end
    @(negedge clk);
    rst = 1'b1;
    any_done = 0;
    repeat (W + 4) begin
      @(negedge clk); #1;
      if (bus.done === 1'b1 || bus.stall === 1'b1) any_done = 1;
    end
    n_checks++; if (any_done) begin n_fail++; $display("FAIL midrst_discard: got activity 1 expected 0"); end
    run_op(2'd2, 32'd100, 32'd7);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.op = 2'd0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
    test_reset();
    test_directed();
    test_divzero();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_muldiv_ctrl.md
Name: exe_muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer beside the EXE stage ALU; iterates one bit per cycle over the already-forwarded operands.
- Issues stall to the hazard/freeze logic while busy.
- Writes the HI/LO result registers.
- Single-cycle ALU operations never touch this block.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  EXE holds a mul/div instruction with forwarded operands
op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
op_a  in  WIDTH  forwarded first operand (multiplicand / dividend)
op_b  in  WIDTH  forwarded second operand (multiplier / divisor)
flush  in  1  branch-taken kill of the instruction in EXE
stall  out  1  freeze IF/ID/EXE pipeline registers
done  out  1  one-cycle pulse: HI/LO just updated
hi  out  WIDTH  product[63:32] or remainder
lo  out  WIDTH  product[31:0] or quotient
div_zero  out  1  sticky until next start: last divide had op_b == 0

Behaviour:
- Reset (rst low, any time, including mid-operation):
  - state = IDLE; hi, lo, counter, div_zero = 0; stall = 0; done = 0.
  - Any in-flight result is discarded.
- States:
  - IDLE: no operation in progress.
  - CALC: iterating.
  - DONE: one cycle; result committed.
- IDLE:
  - If start=1 and flush=0: latch magnitudes |op_a|, |op_b| (signed ops only; unsigned ops take operands as-is), result sign, dividend sign, op; clear div_zero; counter = WIDTH; go to CALC.
  - If start=1 and flush=1: ignored; stay in IDLE.
- Divide with op_b == 0 in IDLE: skip CALC, go to DONE next cycle with lo = all ones, hi = op_a, div_zero = 1.
- CALC:
  - One iteration per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter decrements each cycle; counter reaching 1 moves the FSM to DONE.
  - Exactly WIDTH cycles in CALC.
- Entering DONE:
  - Multiply: {hi, lo} = 64-bit product, negated (two's complement) if the result sign is negative.
  - Divide: lo = quotient, negated if the operand signs differ; hi = remainder, taking the sign of the dividend.
  - MULT/DIV edge: -2^31 / -1 yields lo = 0x80000000, hi = 0 (no trap).
- DONE:
  - done = 1 for exactly this cycle.
  - If start=1 (back-to-back): accept as from IDLE, go to CALC.
  - Otherwise go to IDLE.
- stall: stall = (IDLE & start & ~flush) | CALC | (DONE & start & ~flush). It is combinational on start/flush, so the instruction is held in EXE until its result is committed. stall is 0 in the DONE cycle unless a new start is accepted.
- Latency: start accepted at cycle N; done at N+WIDTH+1 (N+1 for divide-by-zero).
- flush during CALC: abort to IDLE next cycle; hi, lo, div_zero unchanged; no done pulse.
- start during CALC: ignored; the pipeline is stalled and operands stay stable.
- op_a/op_b changes after acceptance: no effect; operands are latched.
- hi/lo change only on entering DONE or on reset.

Decomposition:
- Shared package holds:
  - op encodings MULTU/MULT/DIVU/DIV;
  - state encoding IDLE/CALC/DONE;
  - WIDTH default;
  - DIVZ_QUOT constant (all ones).
- One natural sub-module: muldiv_sign_fix. Combinational; takes the magnitude result, sign flags and op, and produces signed hi/lo. It is reused for operand abs at entry.
- FSM, counter and datapath registers stay in exe_muldiv_ctrl.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at cycle 10 -> stall cycles 10..42, done at cycle 43, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -7 x 6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- DIVU 5 / 0 -> done one cycle after start, lo=0xFFFFFFFF, hi=5, div_zero=1; the next start clears div_zero.
- Complete a MULTU 3 x 4 (hi=0, lo=12). Then start a new MULTU and assert flush at its 10th CALC cycle -> IDLE next cycle, no done, hi/lo still 0/12, stall drops.
- Back-to-back:
  - start held during DONE -> second op accepted with no IDLE gap; second done exactly WIDTH+1 cycles after the first.
  - rst pulled low mid-CALC -> hi=lo=0, stall=0 immediately (asynchronous).
